mux_scan_ctrl: RTL and testbench

- Sequences the 8:1 sensor mux by driving its 3-bit select, stepping through the eight sensor inputs one at a time (round-robin).
- Samples the mux output after a settle delay and debounces each channel independently.
- Emits one handshaked event per debounced level change, tagged with the channel index and the new level.
- Sits between the sensor mux and the visitor up/down counter logic, which consumes the events.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/chan_debounce.sv | 41 ++++
 rtl/mux_scan_ctrl.sv | 105 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the sensor mux scan controller.
// Channel count, select width, debounce counter width and the controller state enum.
package mux_scan_pkg;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      EMIT
   } state_t;

endpackage

// File: rtl/chan_debounce.sv
// One channel's debouncer: a stable level plus a count of consecutive differing samples.
// change_pulse flags the sample that will flip the stable level at the next edge.
module chan_debounce
   import mux_scan_pkg::*;
#(
   parameter int DEBOUNCE_N = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic sample,
   output logic level,
   output logic change_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

   logic [CNT_W-1:0] cnt;
   logic             last_count;

   assign last_count   = (cnt == CNT_LAST);
   assign change_pulse = sample_en && (sample != level) && last_count;

   // The count only moves on this channel's sample slot and tops out at DEBOUNCE_N-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sample_en) begin
         if (sample == level) begin
            cnt <= '0;
         end else if (last_count) begin
            level <= sample;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scanner for the 8:1 sensor mux: settle, sample, debounce per channel,
// and hand one level-change event at a time to the visitor counter logic.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int DEBOUNCE_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mux_out,
   output logic [CH_W-1:0]   sel,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CH_W-1:0]   evt_ch,
   output logic              evt_level,
   output logic [NUM_CH-1:0] level
);

   state_t             state, next_state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [NUM_CH-1:0]  sample_en;
   logic [NUM_CH-1:0]  change_pulse;
   logic               any_change;
   logic               handshake;
   logic               take_event;
   logic               advance;
   logic               load_settle;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      assign sample_en[i] = (state == SAMPLE) && (sel == CH_W'(i));

      chan_debounce #(
         .DEBOUNCE_N (DEBOUNCE_N)
      ) u_deb (
         .clk          (clk),
         .rst          (rst),
         .sample_en    (sample_en[i]),
         .sample       (mux_out),
         .level        (level[i]),
         .change_pulse (change_pulse[i])
      );
   end

   assign any_change = |change_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A channel always runs to completion once started; en is only consulted when leaving it.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en) next_state = SETTLE;
         SETTLE:  if (settle_cnt == '0) next_state = SAMPLE;
         SAMPLE:  begin
            if (any_change) next_state = EMIT;
            else            next_state = en ? SETTLE : IDLE;
         end
         EMIT:    if (evt_valid && evt_ready) next_state = en ? SETTLE : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      handshake   = (state == EMIT) && evt_valid && evt_ready;
      take_event  = (state == SAMPLE) && any_change;
      advance     = ((state == SAMPLE) && !any_change) || handshake;
      load_settle = (next_state == SETTLE) && (state != SETTLE);
   end

   // Select only moves when a channel is finished, so a stalled event also stalls the scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         sel        <= '0;
         evt_valid  <= 1'b0;
         evt_ch     <= '0;
         evt_level  <= 1'b0;
      end else begin
         if (load_settle) begin
            settle_cnt <= CNT_W'(SETTLE_CYC - 1);
         end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
         if (advance) begin
            sel <= sel + 1'b1;
         end
         if (take_event) begin
            evt_valid <= 1'b1;
            evt_ch    <= sel;
            evt_level <= mux_out;
         end else if (handshake) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus a randomized run,
// all compared every cycle against a slot-based behavioural model of the scanner.
module tb_mux_scan_ctrl;

   localparam int SETTLE_CYC = 2;
   localparam int DEBOUNCE_N = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       mux_out;
   logic [2:0] sel;
   logic       evt_valid;
   logic       evt_ready = 1'b1;
   logic [2:0] evt_ch;
   logic       evt_level;
   logic [7:0] level;
   logic [7:0] sensors = 8'h00;

   int n_checks = 0;
   int n_fail = 0;

   // Model: which channel is in its slot, how far into the slot, and any held event.
   int       m_ch;
   bit       m_active;
   int       m_age;
   bit       m_pend;
   int       m_evt_ch;
   bit       m_evt_lvl;
   int       m_cnt [8];
   bit [7:0] m_lvl;
   int       m_sampled;

   always #5 clk = ~clk;

   assign mux_out = sensors[sel];

   mux_scan_ctrl #(
      .SETTLE_CYC (SETTLE_CYC),
      .DEBOUNCE_N (DEBOUNCE_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mux_out   (mux_out),
      .sel       (sel),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_level (evt_level),
      .level     (level)
   );

   function automatic void model_advance();
      m_ch = (m_ch + 1) % 8;
      m_active = en;
      m_age = 0;
   endfunction

   function automatic void model_update();
      bit s;
      m_sampled = -1;
      if (rst) begin
         m_ch = 0; m_active = 0; m_age = 0; m_pend = 0;
         m_evt_ch = 0; m_evt_lvl = 0; m_lvl = 8'h00;
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else if (m_pend) begin
         if (evt_ready) begin
            m_pend = 0;
            model_advance();
         end
      end else if (!m_active) begin
         if (en) begin
            m_active = 1;
            m_age = 0;
         end
      end else if (m_age < SETTLE_CYC) begin
         m_age++;
      end else begin
         s = sensors[m_ch];
         m_sampled = m_ch;
         if (s == m_lvl[m_ch]) begin
            m_cnt[m_ch] = 0;
         end else if (m_cnt[m_ch] + 1 == DEBOUNCE_N) begin
            m_lvl[m_ch] = s;
            m_cnt[m_ch] = 0;
            m_pend = 1;
            m_evt_ch = m_ch;
            m_evt_lvl = s;
         end else begin
            m_cnt[m_ch]++;
         end
         if (!m_pend) model_advance();
      end
   endfunction

   function automatic logic [15:0] model_vec();
      return {3'(m_ch), m_pend, 3'(m_evt_ch), m_evt_lvl, m_lvl};
   endfunction

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; evt_ready = 1'b1; sensors = 8'h00;
      step();
      step();
      n_checks++;
      if ({sel, evt_valid, evt_ch, evt_level, level} !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_state got %h expected 0000", {sel, evt_valid, evt_ch, evt_level, level});
      end
      rst = 1'b0;
      for (int c = 0; c < 50; c++) begin
         step();
         n_checks++;
         if (sel !== 3'd0 || {sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL idle_park cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
      end
   endtask

   task automatic test_sweep();
      int run_len;
      logic [2:0] prev_sel;
      en = 1'b1;
      run_len = 0;
      prev_sel = sel;
      for (int c = 0; c < 100; c++) begin
         step();
         n_checks++;
         if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec() || evt_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sweep cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
         if (sel == prev_sel) begin
            run_len++;
         end else begin
            n_checks++;
            if (sel !== prev_sel + 3'd1 || (c > 3 && run_len !== SETTLE_CYC + 1)) begin
               n_fail++;
               $display("[TB] FAIL sweep_cadence sel %0d after %0d got run %0d expected %0d", sel, prev_sel, run_len, SETTLE_CYC + 1);
            end
            run_len = 1;
            prev_sel = sel;
         end
      end
   endtask

   task automatic test_debounce();
      bit seen;
      for (int phase = 0; phase < 2; phase++) begin
         sensors[5] = (phase == 0);
         seen = 0;
         for (int c = 0; c < 200 && !seen; c++) begin
            step();
            n_checks++;
            if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
               n_fail++;
               $display("[TB] FAIL debounce cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
            end
            if (evt_valid === 1'b1) begin
               seen = 1;
               n_checks++;
               if (evt_ch !== 3'd5 || evt_level !== (phase == 0) || level !== ((phase == 0) ? 8'h20 : 8'h00)) begin
                  n_fail++;
                  $display("[TB] FAIL debounce_event got ch %0d lvl %0d level %h expected ch 5 lvl %0d", evt_ch, evt_level, level, (phase == 0));
               end
            end
         end
         n_checks++;
         if (!seen) begin
            n_fail++;
            $display("[TB] FAIL debounce_timeout phase %0d got no event expected one", phase);
         end
         step();
         n_checks++;
         if (evt_valid !== 1'b0 || sel !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL debounce_pulse got valid %0d sel %0d expected valid 0 sel 6", evt_valid, sel);
         end
      end
   endtask

   task automatic test_glitch();
      int samples = 0;
      sensors[2] = 1'b1;
      for (int c = 0; c < 200 && samples < 2; c++) begin
         step();
         if (m_sampled == 2) samples++;
      end
      sensors[2] = 1'b0;
      for (int c = 0; c < 80; c++) begin
         step();
         n_checks++;
         if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec() || evt_valid !== 1'b0 || level[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL glitch cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      bit seen = 0;
      evt_ready = 1'b0;
      sensors[3] = 1'b1;
      for (int c = 0; c < 200 && !seen; c++) begin
         step();
         if (evt_valid === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL stall_timeout got no event expected ch3 event");
      end
      sensors[6] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if (evt_valid !== 1'b1 || evt_ch !== 3'd3 || sel !== 3'd3 || {sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL stall_hold cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
      end
      evt_ready = 1'b1;
      step();
      n_checks++;
      if (evt_valid !== 1'b0 || sel !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL stall_release got valid %0d sel %0d expected valid 0 sel 4", evt_valid, sel);
      end
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         step();
         n_checks++;
         if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL after_stall cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
         if (evt_valid === 1'b1 && evt_ch === 3'd6) seen = 1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL stall_lost_change got no ch6 event expected one");
      end
   endtask

   task automatic test_mid_reset();
      bit seen = 0;
      evt_ready = 1'b0;
      sensors[7] = 1'b1;
      for (int c = 0; c < 200 && !seen; c++) begin
         step();
         if (evt_valid === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL midreset_timeout got no event expected ch7 event");
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      evt_ready = 1'b1;
      n_checks++;
      if ({sel, evt_valid, evt_ch, evt_level, level} !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL midreset_clear got %h expected 0000", {sel, evt_valid, evt_ch, evt_level, level});
      end
      for (int c = 0; c < 150; c++) begin
         step();
         n_checks++;
         if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL midreset_rescan cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
      end
      n_checks++;
      if (level !== 8'hC8) begin
         n_fail++;
         $display("[TB] FAIL midreset_relearn got level %h expected c8", level);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) sensors[$urandom_range(0, 7)] ^= 1'b1;
         evt_ready = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 15) != 0);
         step();
         n_checks++;
         if ({sel, evt_valid, evt_ch, evt_level, level} !== model_vec()) begin
            n_fail++;
            $display("[TB] FAIL random cycle %0d got %h expected %h", c, {sel, evt_valid, evt_ch, evt_level, level}, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_debounce();
      test_glitch();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
